// File: rtl/qspi_rd_ram_pkg.sv
// rtl/qspi_rd_ram_pkg.sv - shared QSPI frame definitions: FSM states, opcodes, phase lengths
package qspi_rd_ram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_HOLD  = 3'd5
    } qspi_state_t;

    localparam logic [7:0] QSPI_RD_CMD = 8'hEB;

    localparam int CMD_BITS  = 8;
    localparam int ADDR_NIBS = 6;

endpackage

// File: rtl/qspi_tx_shreg.sv
// rtl/qspi_tx_shreg.sv - W-bit load / shift-by-4 register, top nibble drives io[3:0]
module qspi_tx_shreg #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_data,
    output logic [3:0]   o_nib
);

    logic [W-1:0] r_sh;

    // Load a fresh word or shift the next nibble up to the output position
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_sh <= '0;
        end else if (i_load) begin
            r_sh <= i_data;
        end else if (i_shift) begin
            r_sh <= {r_sh[W-5:0], 4'h0};
        end
    end

    assign o_nib = r_sh[W-1 -: 4];

endmodule

// File: rtl/qspi_rd_ram.sv
// rtl/qspi_rd_ram.sv - QSPI quad-read slave streaming buffer RAM words; QSPI_RD_CMD_CHECK_EN enables opcode check
module qspi_rd_ram
    import qspi_rd_ram_pkg::*;
#(
    parameter logic [7:0] RD_CMD    = QSPI_RD_CMD,
    parameter int         DUMMY_CYC = 4,
    parameter int         RAM_AW    = 3,
    parameter int         RAM_DW    = 16
) (
    input  logic              qspi_clk,
    input  logic              rst_n,
    input  logic              qspi_csn,
    input  logic [3:0]        qspi_io_i,
    output logic [3:0]        qspi_io_o,
    output logic              qspi_io_oe,
    output logic [23:0]       qspi_rd_addr,
    output logic              qspi_rd_req,
    output logic              ram_ren,
    output logic [RAM_AW-1:0] ram_raddr,
    input  logic [RAM_DW-1:0] ram_rdata
);

`ifdef QSPI_RD_CMD_CHECK_EN
    localparam bit CMD_CHECK = 1'b1;
`else
    localparam bit CMD_CHECK = 1'b0;
`endif

    localparam int NIB = RAM_DW / 4;

    localparam logic [7:0] CNT_CMD_LAST  = 8'(CMD_BITS - 1);
    localparam logic [7:0] CNT_ADDR_LAST = 8'(ADDR_NIBS - 1);
    localparam logic [7:0] CNT_DUM_LAST  = 8'(DUMMY_CYC - 1);
    localparam logic [7:0] CNT_PREFETCH  = 8'(DUMMY_CYC - 2);
    localparam logic [7:0] NIB_LAST      = 8'(NIB - 1);
    localparam logic [7:0] NIB_REN       = 8'(NIB - 2);

    qspi_state_t       r_state;
    qspi_state_t       w_state_nxt;

    logic [7:0]        r_cnt;
    logic [7:0]        r_nib;
    logic [6:0]        r_cmd;
    logic [19:0]       r_addr_sh;

    logic              r_io_oe;
    logic [23:0]       r_rd_addr;
    logic              r_rd_req;
    logic              r_ram_ren;
    logic [RAM_AW-1:0] r_ram_raddr;

    logic [7:0]        w_cmd_byte;
    logic              w_cmd_reject;
    logic [7:0]        w_nib_nxt;
    logic              w_oe_nxt;
    logic              w_req_nxt;
    logic              w_ren_nxt;
    logic [RAM_AW-1:0] w_raddr_nxt;
    logic              w_load_addr;
    logic              w_sh_clr;
    logic              w_sh_load;
    logic              w_sh_shift;
    logic [3:0]        w_tx_nib;

    assign w_cmd_byte   = {r_cmd, qspi_io_i[0]};
    assign w_cmd_reject = CMD_CHECK && (w_cmd_byte != RD_CMD);
    assign w_nib_nxt    = (r_nib == NIB_LAST) ? 8'd0 : r_nib + 8'd1;

    // State register
    always_ff @(posedge qspi_clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; csn high always aborts back to IDLE
    always_comb begin
        w_state_nxt = r_state;
        if (qspi_csn) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_CMD;
                ST_CMD:   if (r_cnt == CNT_CMD_LAST)
                              w_state_nxt = w_cmd_reject ? ST_HOLD : ST_ADDR;
                ST_ADDR:  if (r_cnt == CNT_ADDR_LAST) w_state_nxt = ST_DUMMY;
                ST_DUMMY: if (r_cnt == CNT_DUM_LAST)  w_state_nxt = ST_DATA;
                ST_DATA:  w_state_nxt = ST_DATA;
                ST_HOLD:  w_state_nxt = ST_HOLD;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output decode: next values of the registered pins and shifter controls
    always_comb begin
        w_oe_nxt    = 1'b0;
        w_req_nxt   = 1'b0;
        w_ren_nxt   = 1'b0;
        w_raddr_nxt = r_ram_raddr;
        w_load_addr = 1'b0;
        w_sh_clr    = 1'b0;
        w_sh_load   = 1'b0;
        w_sh_shift  = 1'b0;
        if (qspi_csn) begin
            w_sh_clr = 1'b1;
        end else begin
            case (r_state)
                ST_ADDR: begin
                    if (r_cnt == CNT_ADDR_LAST) begin
                        w_load_addr = 1'b1;
                        w_req_nxt   = 1'b1;
                        // with only two dummy clocks the prefetch starts in dummy cycle 0
                        if (CNT_PREFETCH == 8'd0) begin
                            w_ren_nxt   = 1'b1;
                            w_raddr_nxt = '0;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (r_cnt + 8'd1 == CNT_PREFETCH) begin
                        w_ren_nxt   = 1'b1;
                        w_raddr_nxt = '0;
                    end
                    if (r_cnt == CNT_DUM_LAST) begin
                        w_sh_load = 1'b1;
                        w_oe_nxt  = 1'b1;
                    end
                end
                ST_DATA: begin
                    w_oe_nxt = 1'b1;
                    if (r_nib == NIB_LAST) w_sh_load  = 1'b1;
                    else                   w_sh_shift = 1'b1;
                    // fetch the next word so it lands exactly when this one runs out
                    if (w_nib_nxt == NIB_REN) begin
                        w_ren_nxt   = 1'b1;
                        w_raddr_nxt = r_ram_raddr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Phase counters, command/address shifters and registered pins
    always_ff @(posedge qspi_clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_nib       <= '0;
            r_cmd       <= '0;
            r_addr_sh   <= '0;
            r_io_oe     <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_req    <= 1'b0;
            r_ram_ren   <= 1'b0;
            r_ram_raddr <= '0;
        end else begin
            r_io_oe     <= w_oe_nxt;
            r_rd_req    <= w_req_nxt;
            r_ram_ren   <= w_ren_nxt;
            r_ram_raddr <= w_raddr_nxt;
            if (w_load_addr) r_rd_addr <= {r_addr_sh, qspi_io_i};
            if (qspi_csn) begin
                r_cnt     <= '0;
                r_nib     <= '0;
                r_cmd     <= '0;
                r_addr_sh <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_cmd <= {6'd0, qspi_io_i[0]};
                        r_cnt <= 8'd1;
                    end
                    ST_CMD: begin
                        r_cmd <= {r_cmd[5:0], qspi_io_i[0]};
                        r_cnt <= (r_cnt == CNT_CMD_LAST) ? 8'd0 : r_cnt + 8'd1;
                    end
                    ST_ADDR: begin
                        r_addr_sh <= {r_addr_sh[15:0], qspi_io_i};
                        r_cnt     <= (r_cnt == CNT_ADDR_LAST) ? 8'd0 : r_cnt + 8'd1;
                    end
                    ST_DUMMY: begin
                        r_cnt <= (r_cnt == CNT_DUM_LAST) ? 8'd0 : r_cnt + 8'd1;
                        r_nib <= '0;
                    end
                    ST_DATA: r_nib <= w_nib_nxt;
                    default: ;
                endcase
            end
        end
    end

    qspi_tx_shreg #(
        .W(RAM_DW)
    ) u_tx_shreg (
        .i_clk   (qspi_clk),
        .i_rst_n (rst_n),
        .i_clr   (w_sh_clr),
        .i_load  (w_sh_load),
        .i_shift (w_sh_shift),
        .i_data  (ram_rdata),
        .o_nib   (w_tx_nib)
    );

    assign qspi_io_o    = w_tx_nib;
    assign qspi_io_oe   = r_io_oe;
    assign qspi_rd_addr = r_rd_addr;
    assign qspi_rd_req  = r_rd_req;
    assign ram_ren      = r_ram_ren;
    assign ram_raddr    = r_ram_raddr;

endmodule

// File: tb/tb_qspi_rd_ram.sv
// tb/tb_qspi_rd_ram.sv - self-checking bench for qspi_rd_ram (frame table plus random frames)
module tb_qspi_rd_ram;

    localparam int DUMMY = 4;
    localparam int AW    = 3;
    localparam int DW    = 16;
    localparam int NIB   = DW / 4;
    localparam int WORDS = 1 << AW;

`ifdef QSPI_RD_CMD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          csn;
    logic [3:0]    io_i;
    logic [3:0]    io_o;
    logic          io_oe;
    logic [23:0]   rd_addr;
    logic          rd_req;
    logic          ram_ren;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata = '0;

    logic [DW-1:0] mem [WORDS];
    logic [23:0]   exp_rd_addr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          n_edges;
        bit          rst_end;
        bit          accept;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    // read-buffer RAM: data valid the cycle after the read enable
    always @(posedge clk) begin
        if (ram_ren) ram_rdata <= mem[ram_raddr];
    end

    qspi_rd_ram #(
        .RD_CMD(8'hEB), .DUMMY_CYC(DUMMY), .RAM_AW(AW), .RAM_DW(DW)
    ) dut (
        .qspi_clk     (clk),
        .rst_n        (rst_n),
        .qspi_csn     (csn),
        .qspi_io_i    (io_i),
        .qspi_io_o    (io_o),
        .qspi_io_oe   (io_oe),
        .qspi_rd_addr (rd_addr),
        .qspi_rd_req  (rd_req),
        .ram_ren      (ram_ren),
        .ram_raddr    (ram_raddr),
        .ram_rdata    (ram_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_oe"},    32'(io_oe),     32'd0);
        chk({tag, "_io"},    32'(io_o),      32'd0);
        chk({tag, "_req"},   32'(rd_req),    32'd0);
        chk({tag, "_ren"},   32'(ram_ren),   32'd0);
        chk({tag, "_raddr"}, 32'(ram_raddr), 32'd0);
        chk({tag, "_addr"},  32'(rd_addr),   32'd0);
    endtask

    // Drive one frame of n_edges clocks with csn low and compare each cycle
    // against the frame rules: req after the 14th edge, prefetch two cycles
    // before data, one nibble per clock from the first data cycle onward.
    task automatic run_frame(input vec_t v);
        int          j;
        int          data_start;
        int          ren_start;
        logic [DW-1:0] word;
        bit          e_oe;
        bit          e_ren;
        data_start = 14 + DUMMY - 1;
        ren_start  = data_start - 2;
        for (int e = 0; e < v.n_edges; e++) begin
            csn  = 1'b0;
            io_i = 4'($urandom);
            if (e < 8)       io_i[0] = v.cmd[7-e];
            else if (e < 14) io_i    = v.addr[23-4*(e-8) -: 4];
            @(posedge clk); #1;
            if (v.accept && e == 13) exp_rd_addr = v.addr;
            e_oe  = v.accept && e >= data_start;
            e_ren = v.accept && e >= ren_start && ((e - ren_start) % NIB == 0);
            chk("rd_req",  32'(rd_req),  32'(v.accept && e == 13));
            chk("rd_addr", 32'(rd_addr), 32'(exp_rd_addr));
            chk("io_oe",   32'(io_oe),   32'(e_oe));
            chk("ram_ren", 32'(ram_ren), 32'(e_ren));
            if (e_ren)
                chk("ram_raddr", 32'(ram_raddr), 32'(((e - ren_start) / NIB) % WORDS));
            if (e_oe) begin
                j    = e - data_start;
                word = mem[(j / NIB) % WORDS];
                chk("io_o", 32'(io_o), 32'((word >> (4 * (NIB - 1 - (j % NIB)))) & 16'hF));
            end
        end
        if (v.rst_end) begin
            rst_n = 1'b0;
            csn   = 1'b0;
            @(posedge clk); #1;
            exp_rd_addr = '0;
            chk_all_zero("midrst");
            rst_n = 1'b1;
        end
        csn = 1'b1;
        @(posedge clk); #1;
        chk("end_oe",  32'(io_oe),   32'd0);
        chk("end_req", 32'(rd_req),  32'd0);
        chk("end_ren", 32'(ram_ren), 32'd0);
    endtask

    initial begin
        vec_t rv;
        mem[0] = 16'hA5C3;
        mem[1] = 16'h1234;
        for (int i = 2; i < WORDS; i++) mem[i] = 16'($urandom);

        vecs[0] = '{8'hEB, 24'h123456, 14 + DUMMY - 1 + 8 * NIB, 1'b0, 1'b1};
        vecs[1] = '{8'hEB, 24'hABCDEF, 14 + DUMMY - 1 + 9 * NIB, 1'b0, 1'b1};
        vecs[2] = '{8'hEB, 24'h111111, 11,                       1'b0, 1'b1};
        vecs[3] = '{8'hEB, 24'h654321, 30,                       1'b0, 1'b1};
        vecs[4] = '{8'h03, 24'h123456, 40,                       1'b0, !CHK};
        vecs[5] = '{8'hEB, 24'h0F0F0F, 14 + DUMMY - 1 + 2,       1'b0, 1'b1};
        vecs[6] = '{8'hEB, 24'h777777, 25,                       1'b0, 1'b1};
        vecs[7] = '{8'hEB, 24'h2468AC, 22,                       1'b1, 1'b1};
        vecs[8] = '{8'hEB, 24'h13579B, 25,                       1'b0, 1'b1};

        rst_n = 1'b0;
        csn   = 1'b1;
        io_i  = 4'h0;
        exp_rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_frame(vecs[i]);

        for (int i = 0; i < 12; i++) begin
            rv.cmd     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hEB;
            rv.addr    = 24'($urandom);
            rv.n_edges = $urandom_range(1, 60);
            rv.rst_end = 1'b0;
            rv.accept  = (rv.cmd == 8'hEB) || !CHK;
            run_frame(rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
